// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: feeds stream words bit-serially, LSB first, onto the ccff_head configuration chain.
// Optional feature macro CCFF_READBACK_EN: a verify pass compares ccff_tail against ccff_head and sets a sticky err.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              cfg_start,
   input  logic              cfg_verify,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BL_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [BL_W-1:0]   bits_left_q, bits_left_d;
   logic [WB_W-1:0]   wbits_q, wbits_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic              ccff_head_q, ccff_head_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // State and datapath registers
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q     <= S_IDLE;
         bits_left_q <= '0;
         wbits_q     <= '0;
         shreg_q     <= '0;
         ccff_head_q <= 1'b0;
         s_ready_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bits_left_q <= bits_left_d;
         wbits_q     <= wbits_d;
         shreg_q     <= shreg_d;
         ccff_head_q <= ccff_head_d;
         s_ready_q   <= s_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start) state_d = S_FETCH;
            else           state_d = S_IDLE;
         end
         S_FETCH: begin
            if (s_valid) state_d = S_SHIFT;
            else         state_d = S_FETCH;
         end
         S_SHIFT: begin
            if (bits_left_q == BL_W'(1))   state_d = S_DONE;
            else if (wbits_q == WB_W'(1))  state_d = S_FETCH;
            else                           state_d = S_SHIFT;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: ccff_head carries the current bit, shreg holds the bits still to come
   always_comb begin
      bits_left_d = bits_left_q;
      wbits_d     = wbits_q;
      shreg_d     = shreg_q;
      ccff_head_d = ccff_head_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_start) bits_left_d = BL_W'(CHAIN_LEN);
            else           bits_left_d = bits_left_q;
         end
         S_FETCH: begin
            if (s_valid) begin
               shreg_d     = s_data >> 1;
               ccff_head_d = s_data[0];
               if (32'(bits_left_q) >= WORD_W) wbits_d = WB_W'(WORD_W);
               else                            wbits_d = WB_W'(bits_left_q);
            end else begin
               shreg_d = shreg_q;
            end
         end
         S_SHIFT: begin
            bits_left_d = bits_left_q - BL_W'(1);
            wbits_d     = wbits_q - WB_W'(1);
            if (state_d == S_SHIFT) begin
               ccff_head_d = shreg_q[0];
               shreg_d     = shreg_q >> 1;
            end else begin
               ccff_head_d = ccff_head_q;
            end
         end
         S_DONE:  bits_left_d = bits_left_q;
         default: bits_left_d = bits_left_q;
      endcase
   end

   // Registered status outputs follow the upcoming state
   always_comb begin
      s_ready_d = (state_d == S_FETCH);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   assign s_ready   = s_ready_q;
   assign ccff_head = ccff_head_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef CCFF_READBACK_EN
   logic vmode_q, vmode_d;
   logic err_q, err_d;

   // During a verify pass ccff_tail shows bit k of the previous pass while ccff_head shows bit k of this one
   always_comb begin
      vmode_d = vmode_q;
      err_d   = err_q;
      if ((state_q == S_IDLE) && cfg_start) begin
         vmode_d = cfg_verify;
         if (cfg_verify) err_d = 1'b0;
         else            err_d = err_q;
      end else if ((state_q == S_SHIFT) && vmode_q && (ccff_tail != ccff_head_q)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Verify-mode and sticky error registers
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         vmode_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         vmode_q <= vmode_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_s;
   assign unused_s = cfg_verify ^ ccff_tail;
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized bench for ccff_chain_loader with a behavioural chain model on ccff_head/ccff_tail.
module tb_ccff_chain_loader;
   localparam int CL = 20;
   localparam int WW = 8;
   localparam int NW = (CL + WW - 1) / WW;
   typedef logic [WW-1:0] word_arr_t [NW];

   logic          prog_clk = 1'b0;
   logic          pReset, cfg_start, cfg_verify, s_valid, ccff_tail;
   logic [WW-1:0] s_data;
   logic          s_ready, ccff_head, busy, done, err;

   ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .cfg_start (cfg_start),
      .cfg_verify(cfg_verify),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .ccff_head (ccff_head),
      .ccff_tail (ccff_tail),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 prog_clk = ~prog_clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] req);
      vectors++;
      if (obs !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
      end
   endtask

   // Chain model: element 0 nearest ccff_head, last element drives ccff_tail
   logic [CL-1:0] chain_m   = '0;
   logic          shift_now = 1'b0;
   logic          head_smp  = 1'b0;
   logic          bits_log [4096];
   int            got_cnt  = 0;
   int            hs_cnt   = 0;
   int            done_cnt = 0;

   assign ccff_tail = chain_m[CL-1];

   // Observer on the falling edge: shift cycles, handshakes, done pulses
   always @(negedge prog_clk) begin
      shift_now <= busy && !s_ready && !done;
      head_smp  <= ccff_head;
      if (busy && !s_ready && !done) begin
         if (got_cnt < 4096) bits_log[got_cnt] <= ccff_head;
         got_cnt <= got_cnt + 1;
      end
      if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   // The chain captures ccff_head at the edge ending each shift cycle
   always @(posedge prog_clk) begin
      if (shift_now) chain_m <= {chain_m[CL-2:0], head_smp};
   end

   logic [63:0] chain_exp = '0;
   logic        exp_err   = 1'b0;
   word_arr_t   last_words;

   function automatic logic [63:0] pack_bits(input word_arr_t w);
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < CL; i++) p[i] = w[i / WW][i % WW];
      return p;
   endfunction

   task automatic run_pass(input string nm, input word_arr_t w, input logic verify,
                           input int stall_w, input int stall_n, input bit poke, input int abort_bit);
      logic [63:0] exp_p, got_p, rb;
      int idx, stalled, c, fetch_at, done_at, shifts, base_got, base_hs, base_done;
      logic err_done;
      exp_p = pack_bits(w);
      idx = 0; stalled = 0; fetch_at = -1; done_at = -1; shifts = 0; err_done = 1'b0;
      base_got = got_cnt; base_hs = hs_cnt; base_done = done_cnt;
`ifdef CCFF_READBACK_EN
      if (verify) exp_err = (exp_p != chain_exp);
`endif
      @(posedge prog_clk); #1;
      cfg_start = 1'b1; cfg_verify = verify;
      @(posedge prog_clk); #1;
      cfg_start = 1'b0; cfg_verify = 1'($urandom_range(0, 1));
      c = 1;
      check_eq({nm, "_ready_lat"}, s_ready, 1);
      while (c < 400 && done_at < 0) begin
         if (s_ready && fetch_at < 0) fetch_at = c;
         if (done) begin done_at = c; err_done = err; end
         if (busy && !s_ready && !done) shifts++;
         if (abort_bit >= 0 && shifts == abort_bit + 1) break;
         cfg_start = poke && (shifts == 3) && busy && !s_ready && !done;
         if (idx < NW) begin
            if (idx == stall_w && stalled < stall_n && s_ready) begin
               s_valid = 1'b0; s_data = WW'($urandom); stalled++;
            end else begin
               s_valid = 1'b1; s_data = w[idx];
               if (s_ready) idx++;
            end
         end else begin
            s_valid = 1'($urandom_range(0, 1)); s_data = WW'($urandom);
         end
         @(posedge prog_clk); #1;
         c++;
      end
      cfg_start = 1'b0;
      if (abort_bit >= 0) begin
         pReset = 1'b1;
         @(negedge prog_clk);
         check_eq({nm, "_rst_ready"}, s_ready, 0);
         check_eq({nm, "_rst_head"}, ccff_head, 0);
         check_eq({nm, "_rst_busy"}, busy, 0);
         check_eq({nm, "_rst_done"}, done, 0);
         check_eq({nm, "_rst_err"}, err, 0);
         @(posedge prog_clk); #1;
         pReset = 1'b0; s_valid = 1'b0;
         repeat (30) @(posedge prog_clk);
         #1;
         check_eq({nm, "_no_done"}, done_cnt - base_done, 0);
         check_eq({nm, "_idle"}, busy, 0);
         exp_err = 1'b0;
         return;
      end
      s_valid = 1'b0;
      check_eq({nm, "_done_seen"}, done_at >= 0, 1);
      check_eq({nm, "_pass_len"}, done_at - fetch_at + 1, CL + NW + 1 + stall_n);
      check_eq({nm, "_err_at_done"}, err_done, exp_err);
      @(posedge prog_clk); #1;
      check_eq({nm, "_done_pulse"}, done, 0);
      check_eq({nm, "_busy_after"}, busy, 0);
      check_eq({nm, "_done_count"}, done_cnt - base_done, 1);
      check_eq({nm, "_words"}, hs_cnt - base_hs, NW);
      check_eq({nm, "_bits"}, got_cnt - base_got, CL);
      got_p = '0;
      rb = '0;
      for (int i = 0; i < CL; i++) begin
         got_p[i] = bits_log[base_got + i];
         rb[i] = chain_m[CL-1-i];
      end
      check_eq({nm, "_head_seq"}, got_p, exp_p);
      check_eq({nm, "_readback"}, rb, exp_p);
      check_eq({nm, "_err_hold"}, err, exp_err);
      chain_exp = exp_p;
      last_words = w;
   endtask

   initial begin
      word_arr_t base_w;
      word_arr_t w;
      pReset = 1'b1; cfg_start = 1'b0; cfg_verify = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(posedge prog_clk);
      #1;
      check_eq("reset_ready", s_ready, 0);
      check_eq("reset_head", ccff_head, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_err", err, 0);
      pReset = 1'b0;
      @(posedge prog_clk); #1;
      check_eq("post_reset_busy", busy, 0);

      base_w[0] = 8'hA5; base_w[1] = 8'h3C; base_w[2] = 8'hF9;
      run_pass("load", base_w, 1'b0, -1, 0, 1'b0, -1);
      run_pass("vfy_stall", base_w, 1'b1, 1, 5, 1'b0, -1);
      w = base_w; w[1] = 8'h3D;
      run_pass("vfy_bad", w, 1'b1, -1, 0, 1'b1, -1);
      for (int k = 0; k < NW; k++) w[k] = WW'($urandom);
      run_pass("plain_sticky", w, 1'b0, -1, 0, 1'b0, -1);
      run_pass("abort", base_w, 1'b0, -1, 0, 1'b0, 11);
      run_pass("restart", base_w, 1'b0, -1, 0, 1'b0, -1);

      for (int r = 0; r < 8; r++) begin
         logic v;
         v = 1'($urandom_range(0, 1));
         if (v && ($urandom_range(0, 2) != 0)) begin
            w = last_words;
            if ($urandom_range(0, 1) == 1) begin
               int k, b;
               k = $urandom_range(0, NW - 1);
               b = $urandom_range(0, WW - 1);
               w[k][b] = ~w[k][b];
            end
         end else begin
            for (int k = 0; k < NW; k++) w[k] = WW'($urandom);
         end
         run_pass("rand", w, v, $urandom_range(0, NW - 1), $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
